// File: rtl/pkt_reg.sv
// Router register block: latches the packet header, routes bytes to the destination
// FIFO write port, diverts a byte while the FIFO is full, and checks packet parity.
module pkt_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic       fifo_full,
    input  logic       detect_addr,
    input  logic       lfd_state,
    input  logic       ld_state,
    input  logic       laf_state,
    input  logic       full_state,
    input  logic       rst_int_reg,
    output logic [7:0] dout,
    output logic       parity_done,
    output logic       low_pkt_valid,
    output logic       err
);

    logic [7:0] header_byte;
    logic [7:0] full_byte;
    logic [7:0] int_parity;
    logic [7:0] pkt_parity;

    // The parity byte is the one presented in load-data with pkt_valid low.
    logic parity_byte;
    assign parity_byte = ld_state && !pkt_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of its neighbours, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            header_byte <= 8'h00;
        end else if (detect_addr && pkt_valid) begin
            header_byte <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'h00;
        end else if (lfd_state) begin
            dout <= header_byte;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (laf_state) begin
            dout <= full_byte;
        end
    end

    // A byte arriving while the FIFO is full is parked here and replayed in laf_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_byte <= 8'h00;
        end else if (ld_state && fifo_full) begin
            full_byte <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_parity <= 8'h00;
        end else if (detect_addr) begin
            int_parity <= 8'h00;
        end else if (lfd_state) begin
            int_parity <= int_parity ^ header_byte;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity <= int_parity ^ data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_parity <= 8'h00;
        end else if (parity_byte) begin
            pkt_parity <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (parity_byte) begin
            low_pkt_valid <= 1'b1;
        end
    end

    // A parity byte diverted to full_byte is only done once laf_state replays it.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_done <= 1'b0;
        end else if (detect_addr) begin
            parity_done <= 1'b0;
        end else if ((parity_byte && !fifo_full) ||
                     (laf_state && low_pkt_valid && !parity_done)) begin
            parity_done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (rst_int_reg) begin
            err <= (int_parity != pkt_parity);
        end else if (detect_addr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pkt_reg.sv
// Self-checking bench for pkt_reg: directed packet scenarios followed by randomized
// packets, checked against a packet-level model of the expected byte stream and parity.
module tb_pkt_reg;

    typedef enum {S_NONE, S_DET, S_LFD, S_LD, S_LAF, S_FULL, S_RINT} st_e;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       fifo_full = 1'b0;
    logic       detect_addr = 1'b0;
    logic       lfd_state = 1'b0;
    logic       ld_state = 1'b0;
    logic       laf_state = 1'b0;
    logic       full_state = 1'b0;
    logic       rst_int_reg = 1'b0;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    pkt_reg dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .detect_addr  (detect_addr),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .dout         (dout),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected observable state, kept at packet/transaction level.
    logic [7:0] exp_dout = 8'h00;
    logic       exp_pd   = 1'b0;
    logic       exp_lpv  = 1'b0;
    logic       exp_err  = 1'b0;
    logic [7:0] par_acc  = 8'h00;

    // Current packet payload and per-byte FIFO-full pattern.
    logic [7:0] pl  [0:15];
    bit         ffb [0:15];
    int         n;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_dout"}, dout, exp_dout);
        chk({tag, "_parity_done"}, {7'd0, parity_done}, {7'd0, exp_pd});
        chk({tag, "_low_pkt_valid"}, {7'd0, low_pkt_valid}, {7'd0, exp_lpv});
        chk({tag, "_err"}, {7'd0, err}, {7'd0, exp_err});
    endtask

    // Apply one cycle of controller decodes and source inputs, then sample 1 after the edge.
    task automatic step(input st_e st, input logic pv, input logic [7:0] d, input logic ff);
        detect_addr = (st == S_DET);
        lfd_state   = (st == S_LFD);
        ld_state    = (st == S_LD);
        laf_state   = (st == S_LAF);
        full_state  = (st == S_FULL);
        rst_int_reg = (st == S_RINT);
        pkt_valid   = pv;
        data_in     = d;
        fifo_full   = ff;
        @(posedge clk);
        #1;
    endtask

    // Full packet: header, n payload bytes (pl/ffb), parity byte, then the parity check.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par, input bit par_full);
        step(S_DET, 1'b1, hdr, 1'b0);
        exp_pd  = 1'b0;
        exp_err = 1'b0;
        check_outs("det");
        chk("det_int_parity", dut.int_parity, 8'h00);

        step(S_LFD, 1'b1, pl[0], 1'b0);
        exp_dout = hdr;
        par_acc  = hdr;
        check_outs("lfd");
        chk("lfd_int_parity", dut.int_parity, hdr);

        for (int i = 0; i < n; i++) begin
            step(S_LD, 1'b1, pl[i], ffb[i]);
            par_acc = par_acc ^ pl[i];
            if (!ffb[i]) exp_dout = pl[i];
            check_outs("ld");
            if (ffb[i]) begin
                chk("ld_full_byte", dut.full_byte, pl[i]);
                step(S_FULL, 1'b1, $urandom_range(255), 1'b1);
                check_outs("full");
                step(S_LAF, 1'b1, $urandom_range(255), 1'b0);
                exp_dout = pl[i];
                check_outs("laf");
            end
        end

        step(S_LD, 1'b0, par, par_full);
        exp_lpv = 1'b1;
        if (!par_full) begin
            exp_pd   = 1'b1;
            exp_dout = par;
        end
        check_outs("parity");
        if (par_full) begin
            step(S_FULL, 1'b0, $urandom_range(255), 1'b1);
            check_outs("parity_full");
            step(S_LAF, 1'b0, $urandom_range(255), 1'b0);
            exp_dout = par;
            exp_pd   = 1'b1;
            check_outs("parity_laf");
        end
        chk("final_int_parity", dut.int_parity, par_acc);

        step(S_RINT, 1'b0, 8'h00, 1'b0);
        exp_err = (par_acc != par);
        exp_lpv = 1'b0;
        check_outs("rint");

        step(S_NONE, 1'($urandom_range(1)), $urandom_range(255), 1'($urandom_range(1)));
        check_outs("idle");
    endtask

    task automatic load_std(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        n = 3;
        pl[0] = b0; pl[1] = b1; pl[2] = b2;
        for (int i = 0; i < 16; i++) ffb[i] = 1'b0;
    endtask

    initial begin
        // Reset, with active inputs applied to show reset wins.
        rst = 1'b1;
        step(S_LD, 1'b1, 8'hA5, 1'b1);
        step(S_LAF, 1'b0, 8'h5A, 1'b0);
        rst = 1'b0;
        check_outs("reset");
        chk("reset_int_parity", dut.int_parity, 8'h00);
        chk("reset_full_byte", dut.full_byte, 8'h00);

        // Normal packet: 0x0D, 0x11/0x22/0x33, parity 0x0D.
        load_std(8'h11, 8'h22, 8'h33);
        send_pkt(8'h0D, 8'h0D, 1'b0);
        chk("normal_int_parity", dut.int_parity, 8'h0D);
        chk("normal_err", {7'd0, err}, 8'h00);

        // Bad parity byte 0x0E; err cleared by the next packet's detect_addr.
        send_pkt(8'h0D, 8'h0E, 1'b0);
        chk("badpar_err", {7'd0, err}, 8'h01);

        // FIFO full on payload byte 0x22.
        load_std(8'h11, 8'h22, 8'h33);
        ffb[1] = 1'b1;
        send_pkt(8'h0D, 8'h0D, 1'b0);
        chk("fullmid_int_parity", dut.int_parity, 8'h0D);
        chk("fullmid_err", {7'd0, err}, 8'h00);

        // FIFO full when the parity byte arrives.
        load_std(8'h11, 8'h22, 8'h33);
        send_pkt(8'h0D, 8'h0D, 1'b1);
        chk("fullpar_dout", dout, 8'h0D);

        // Reset mid-packet after byte 0x22.
        step(S_DET, 1'b1, 8'h0D, 1'b0);
        exp_pd = 1'b0; exp_err = 1'b0;
        check_outs("rmid_det");
        step(S_LFD, 1'b1, 8'h11, 1'b0);
        exp_dout = 8'h0D;
        step(S_LD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h22, 1'b0);
        exp_dout = 8'h22;
        check_outs("rmid_pre");
        rst = 1'b1;
        step(S_LD, 1'b0, 8'h33, 1'b1);
        rst = 1'b0;
        exp_dout = 8'h00; exp_pd = 1'b0; exp_lpv = 1'b0; exp_err = 1'b0;
        check_outs("rmid_rst");
        chk("rmid_int_parity", dut.int_parity, 8'h00);
        n = 1; pl[0] = 8'h44; ffb[0] = 1'b0;
        send_pkt(8'h05, 8'h41, 1'b0);
        chk("post_rst_err", {7'd0, err}, 8'h00);

        // Randomized back-to-back packets.
        for (int p = 0; p < 24; p++) begin
            logic [7:0] hdr;
            logic [7:0] par;
            logic [7:0] good;
            n = $urandom_range(8, 1);
            hdr = {6'(n), 2'($urandom_range(2))};
            good = hdr;
            for (int i = 0; i < n; i++) begin
                pl[i]  = 8'($urandom_range(255));
                ffb[i] = ($urandom_range(3) == 0);
                good   = good ^ pl[i];
            end
            par = ($urandom_range(2) == 0) ? (good ^ 8'($urandom_range(255, 1))) : good;
            send_pkt(hdr, par, ($urandom_range(2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_reg.md
PKT_REG -- requirements
Module: pkt_reg

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: pkt_valid  input  1  source asserts while header/payload bytes are on data_in; low on the parity byte.
REQ-004 SHALL have port: data_in  input  8  packet byte stream; header = {len[5:0], addr[1:0]}.
REQ-005 SHALL have port: fifo_full  input  1  selected destination FIFO is full.
REQ-006 SHALL have ports: detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg  input  1 each  state decodes from the router controller FSM; one-hot or all low.
REQ-007 SHALL have port: dout  output  8  byte presented to destination FIFO write port.
REQ-008 SHALL have port: parity_done  output  1  parity byte has been captured for the current packet.
REQ-009 SHALL have port: low_pkt_valid  output  1  pkt_valid fell while in load-data; packet payload ended.
REQ-010 SHALL have port: err  output  1  computed parity mismatched received parity.

Function
REQ-011 SHALL hold header_byte (8b), full_byte (8b), int_parity (8b) and pkt_parity (8b) internal registers.
REQ-012 SHALL latch header_byte <= data_in when detect_addr && pkt_valid; otherwise hold.
REQ-013 SHALL update dout with priority lfd_state > ld_state > laf_state: lfd_state -> header_byte; ld_state && !fifo_full -> data_in; laf_state -> full_byte; otherwise hold.
REQ-014 SHALL capture full_byte <= data_in when ld_state && fifo_full; dout holds that cycle; full_byte otherwise holds.
REQ-015 SHALL clear int_parity to 0x00 when detect_addr.
REQ-016 SHALL update int_parity ^= header_byte when lfd_state.
REQ-017 SHALL update int_parity ^= data_in when ld_state && pkt_valid && !full_state, including bytes diverted to full_byte; the parity byte (pkt_valid low) is never folded in.
REQ-018 SHALL latch pkt_parity <= data_in when ld_state && !pkt_valid (the parity byte), whether or not fifo_full.
REQ-019 SHALL set low_pkt_valid when ld_state && !pkt_valid; clear it when rst_int_reg; otherwise hold.
REQ-020 SHALL clear parity_done when detect_addr.
REQ-021 SHALL set parity_done when ld_state && !pkt_valid && !fifo_full, or when laf_state && low_pkt_valid && !parity_done; otherwise hold.
REQ-022 SHALL compute err <= (int_parity != pkt_parity) in the cycle rst_int_reg is high; clear err when detect_addr; otherwise hold.
REQ-023 SHALL produce all outputs directly from registers, each with a one-cycle latency from the qualifying input cycle.
REQ-024 SHALL have no FIFO-depth or length checks; packet length is not counted in this block.
REQ-025 SHALL, when all state decodes are low, hold every register.

Reset
REQ-026 SHALL, on rst high at a clock edge, set dout, header_byte, full_byte, int_parity and pkt_parity to 0x00, and parity_done, low_pkt_valid and err to 0.
REQ-027 SHALL give rst priority over every other condition, including mid-packet; the first packet after reset needs detect_addr again.

Verification
REQ-028 SHALL cover the normal packet: header 0x0D, payload 0x11/0x22/0x33, parity 0x0D, fifo_full=0 -> dout sequence 0x0D,0x11,0x22,0x33,0x0D; parity_done=1; low_pkt_valid=1 until rst_int_reg; err=0.
REQ-029 SHALL cover the bad-parity case: same packet with parity byte 0x0E -> err=1 the cycle after rst_int_reg; err=0 after the next detect_addr.
REQ-030 SHALL cover full mid-payload: fifo_full=1 in ld_state on byte 0x22 -> dout holds 0x11 and full_byte=0x22; then laf_state -> dout=0x22; final int_parity=0x0D, err=0.
REQ-031 SHALL cover full on the parity byte: fifo_full=1 when pkt_valid falls -> low_pkt_valid=1, parity_done=0; later laf_state -> parity_done=1 and dout=parity byte.
REQ-032 SHALL cover reset mid-packet: rst after byte 0x22 -> all outputs 0 next cycle; the following packet's header 0x05 gives int_parity starting from 0x05.
REQ-033 SHALL cover back-to-back packets: detect_addr after rst_int_reg -> parity_done, err and int_parity cleared before the second packet's payload.
